// File: rtl/reg_bank_pkg.sv
// Shared constants for the 16x16 register bank: geometry and write-port op encoding.
// The REG_BANK_R0_ZERO_EN macro is consumed by reg_bank_16x16.
package reg_bank_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

endpackage

// File: rtl/reg_bank_16x16_update.sv
// reg_update_unit: combinational next-value and flag logic for the bank's write port.
module reg_update_unit
  import reg_bank_pkg::*;
(
  input  logic [DATA_W-1:0] cur,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  // The extra MSB of sum is the carry on INC and the borrow on DEC.
  always_comb begin
    result = cur;
    carry  = 1'b0;
    sum    = '0;
    case (op)
      OP_LOAD: result = wdata;
      OP_INC: begin
        sum    = {1'b0, cur} + (DATA_W + 1)'(1);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_DEC: begin
        sum    = {1'b0, cur} - (DATA_W + 1)'(1);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_CLR: result = '0;
      default: result = cur;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/reg_bank_16x16.sv
// Sixteen 16-bit registers with a LOAD/INC/DEC/CLR write port and a separate increment port.
// Define REG_BANK_R0_ZERO_EN to hardwire REG0 to zero.
module reg_bank_16x16
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  output logic [DATA_W-1:0] REG0,
  output logic [DATA_W-1:0] REG1,
  output logic [DATA_W-1:0] REG2,
  output logic [DATA_W-1:0] REG3,
  output logic [DATA_W-1:0] REG4,
  output logic [DATA_W-1:0] REG5,
  output logic [DATA_W-1:0] REG6,
  output logic [DATA_W-1:0] REG7,
  output logic [DATA_W-1:0] REG8,
  output logic [DATA_W-1:0] REG9,
  output logic [DATA_W-1:0] REG10,
  output logic [DATA_W-1:0] REG11,
  output logic [DATA_W-1:0] REG12,
  output logic [DATA_W-1:0] REG13,
  output logic [DATA_W-1:0] REG14,
  output logic [DATA_W-1:0] REG15,
  output logic              carry,
  output logic              zero
);

`ifdef REG_BANK_R0_ZERO_EN
  localparam bit R0_HARDWIRED = 1'b1;
`else
  localparam bit R0_HARDWIRED = 1'b0;
`endif

  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] wr_cur;
  logic [DATA_W-1:0] wr_next;
  logic [DATA_W-1:0] inc_next;
  logic              wr_carry;
  logic              wr_zero;
  logic              carry_reg;
  logic              zero_reg;

  assign wr_cur   = reg_q[waddr];
  assign inc_next = reg_q[inc_addr] + DATA_W'(1);

  reg_update_unit u_update (
    .cur    (wr_cur),
    .op     (op),
    .wdata  (wdata),
    .result (wr_next),
    .carry  (wr_carry),
    .zero   (wr_zero)
  );

  // Write port has priority: a colliding increment is silently dropped.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (R0_HARDWIRED && gi == 0) begin : g_zero
      assign reg_q[gi] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] value_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg <= '0;
        end else if (we && waddr == ADDR_W'(gi)) begin
          value_reg <= wr_next;
        end else if (inc_en && inc_addr == ADDR_W'(gi)) begin
          value_reg <= inc_next;
        end
      end
      assign reg_q[gi] = value_reg;
    end
  end

  // Flags follow the computed result even when the target register is hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (we) begin
      carry_reg <= wr_carry;
      zero_reg  <= wr_zero;
    end
  end

  assign carry = carry_reg;
  assign zero  = zero_reg;

  assign REG0  = reg_q[0];
  assign REG1  = reg_q[1];
  assign REG2  = reg_q[2];
  assign REG3  = reg_q[3];
  assign REG4  = reg_q[4];
  assign REG5  = reg_q[5];
  assign REG6  = reg_q[6];
  assign REG7  = reg_q[7];
  assign REG8  = reg_q[8];
  assign REG9  = reg_q[9];
  assign REG10 = reg_q[10];
  assign REG11 = reg_q[11];
  assign REG12 = reg_q[12];
  assign REG13 = reg_q[13];
  assign REG14 = reg_q[14];
  assign REG15 = reg_q[15];

endmodule

// File: tb/tb_reg_bank_16x16.sv
// Randomized bench for reg_bank_16x16 against an array-based behavioural model,
// plus directed checks with hand-computed literal values.
module tb_reg_bank_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  op;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        inc_en;
  logic [3:0]  inc_addr;
  logic [15:0] dut_q [16];
  logic        carry;
  logic        zero;

  logic [15:0] m [16];
  logic        m_carry;
  logic        m_zero;
  bit          check_en = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cyc    = 0;

  always #5 clk = ~clk;

  reg_bank_16x16 dut (
    .clk(clk), .rst(rst), .we(we), .op(op), .waddr(waddr), .wdata(wdata),
    .inc_en(inc_en), .inc_addr(inc_addr),
    .REG0(dut_q[0]),   .REG1(dut_q[1]),   .REG2(dut_q[2]),   .REG3(dut_q[3]),
    .REG4(dut_q[4]),   .REG5(dut_q[5]),   .REG6(dut_q[6]),   .REG7(dut_q[7]),
    .REG8(dut_q[8]),   .REG9(dut_q[9]),   .REG10(dut_q[10]), .REG11(dut_q[11]),
    .REG12(dut_q[12]), .REG13(dut_q[13]), .REG14(dut_q[14]), .REG15(dut_q[15]),
    .carry(carry), .zero(zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    m_carry = 1'b0;
    m_zero  = 1'b0;
  endtask

  // Register-transfer meaning of one clock edge, from the operation rules.
  task automatic model_step();
    logic [15:0] res;
    logic        c;
    res = 16'h0000;
    c   = 1'b0;
    if (we) begin
      case (op)
        2'd0: begin res = wdata;          c = 1'b0;                 end
        2'd1: begin res = m[waddr] + 16'd1; c = (m[waddr] == 16'hFFFF); end
        2'd2: begin res = m[waddr] - 16'd1; c = (m[waddr] == 16'h0000); end
        default: begin res = 16'h0000;    c = 1'b0;                 end
      endcase
      m_carry = c;
      m_zero  = (res == 16'h0000);
    end
    if (inc_en && !(we && inc_addr == waddr)) m[inc_addr] = m[inc_addr] + 16'd1;
    if (we) m[waddr] = res;
`ifdef REG_BANK_R0_ZERO_EN
    m[0] = 16'h0000;
`endif
  endtask

  task automatic drive(input logic w, input logic [1:0] o, input logic [3:0] wa,
                       input logic [15:0] wd, input logic ie, input logic [3:0] ia);
    we = w; op = o; waddr = wa; wdata = wd; inc_en = ie; inc_addr = ia;
    @(posedge clk);
    model_step();
    n_cyc++;
    $display("cyc %0d: we=%0b op=%0d waddr=%0d wdata=%h inc_en=%0b inc_addr=%0d",
             n_cyc, w, o, wa, wd, ie, ia);
    #1;
  endtask

  // Single per-cycle comparison of the full visible state against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int bad;
      bad = -1;
      for (int i = 15; i >= 0; i--) if (dut_q[i] !== m[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL cycle_regs t=%0t: REG%0d got %h, expected %h", $time, bad, dut_q[bad], m[bad]);
      end else if (carry !== m_carry || zero !== m_zero) begin
        n_fail++;
        $display("FAIL cycle_flags t=%0t: carry/zero got %b%b, expected %b%b",
                 $time, carry, zero, m_carry, m_zero);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r0_exp;
    rst = 1'b1; we = 1'b0; op = 2'd0; waddr = 4'd0; wdata = 16'h0000;
    inc_en = 1'b0; inc_addr = 4'd0;
    model_reset();
    #12;
    for (int i = 0; i < 16; i++) check($sformatf("reset_reg%0d", i), dut_q[i], 16'h0000);
    check("reset_carry", carry, 1'b0);
    check("reset_zero", zero, 1'b0);
    #1 rst = 1'b0;
    check_en = 1'b1;

    drive(1'b1, 2'd0, 4'd5, 16'h1234, 1'b0, 4'd0);
    check("load_r5", dut_q[5], 16'h1234);

    drive(1'b1, 2'd0, 4'd3, 16'hFFFF, 1'b0, 4'd0);
    drive(1'b1, 2'd1, 4'd3, 16'h0000, 1'b0, 4'd0);
    check("inc_wrap_reg", dut_q[3], 16'h0000);
    check("inc_wrap_carry", carry, 1'b1);
    check("inc_wrap_zero", zero, 1'b1);

    drive(1'b1, 2'd3, 4'd7, 16'hBEEF, 1'b0, 4'd0);
    drive(1'b1, 2'd2, 4'd7, 16'h0000, 1'b0, 4'd0);
    check("dec_borrow_reg", dut_q[7], 16'hFFFF);
    check("dec_borrow_carry", carry, 1'b1);
    check("dec_borrow_zero", zero, 1'b0);

    // Increment-port wrap of R7 must leave the write-port flags alone.
    for (int i = 0; i < 3; i++) drive(1'b0, 2'd1, 4'd0, 16'h0000, 1'b1, 4'd7);
    check("hold_reg7", dut_q[7], 16'h0002);
    check("hold_carry", carry, 1'b1);
    check("hold_zero", zero, 1'b0);

    drive(1'b1, 2'd0, 4'd9, 16'h0004, 1'b0, 4'd0);
    drive(1'b1, 2'd0, 4'd2, 16'h00AA, 1'b1, 4'd2);
    check("collide_same", dut_q[2], 16'h00AA);
    drive(1'b1, 2'd0, 4'd2, 16'h00AA, 1'b1, 4'd9);
    check("collide_diff_r2", dut_q[2], 16'h00AA);
    check("collide_diff_r9", dut_q[9], 16'h0005);

    drive(1'b1, 2'd0, 4'd0, 16'h5555, 1'b0, 4'd0);
`ifdef REG_BANK_R0_ZERO_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'h5555;
`endif
    check("load_r0", dut_q[0], r0_exp);
    drive(1'b1, 2'd1, 4'd0, 16'h0000, 1'b1, 4'd0);
    check("inc_r0_zero", zero, 1'b0);
    check("inc_r0_carry", carry, 1'b0);

    // Reset mid-cycle with a pending LOAD; the LOAD lands on the first edge after release.
    we = 1'b1; op = 2'd0; waddr = 4'd11; wdata = 16'hCAFE;
    #2 check_en = 1'b0; rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) check($sformatf("midreset_reg%0d", i), dut_q[i], 16'h0000);
    check("midreset_carry", carry, 1'b0);
    check("midreset_zero", zero, 1'b0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    check_en = 1'b1;
    drive(1'b1, 2'd0, 4'd11, 16'hCAFE, 1'b0, 4'd0);
    check("post_reset_load", dut_q[11], 16'hCAFE);

    for (int n = 0; n < 1500; n++) begin
      logic [15:0] wd;
      logic [3:0]  wa;
      logic [3:0]  ia;
      case ($urandom_range(0, 7))
        0: wd = 16'hFFFF;
        1: wd = 16'h0000;
        2: wd = 16'hFFFE;
        default: wd = 16'($urandom);
      endcase
      wa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ia = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      drive(1'($urandom_range(0, 2) != 0), 2'($urandom), wa, wd,
            1'($urandom_range(0, 1)), ia);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
